frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/frame_capture_ctrl_if.sv | 27 ++
 rtl/frame_capture_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_ctrl_if.sv
// Video stream and DMA buffer-swap signals shared by the capture
// controller and its environment.
interface frame_capture_ctrl_if;
    logic        stream_valid;
    logic        stream_sop;
    logic        stream_eop;
    logic        stream_ready_in;
    logic        stream_ready_out;
    logic        out_valid;
    logic [31:0] dma_write_addr;
    logic        dma_swap_req;
    logic        dma_swap_ack;

    modport master (
        output stream_valid, stream_sop, stream_eop,
        output stream_ready_in, dma_swap_ack,
        input  stream_ready_out, out_valid,
        input  dma_write_addr, dma_swap_req
    );

    modport slave (
        input  stream_valid, stream_sop, stream_eop,
        input  stream_ready_in, dma_swap_ack,
        output stream_ready_out, out_valid,
        output dma_write_addr, dma_swap_req
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Double-buffered frame capture controller: gates a video stream into
// the DMA back buffer and swaps front/back on each completed frame.
module frame_capture_ctrl #(
    parameter logic [31:0] BUF0_ADDR    = 32'h0800_0000,
    parameter logic [31:0] BUF1_ADDR    = 32'h0804_0000,
    parameter int unsigned SWAP_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_start,
    input  logic                  cmd_single,
    input  logic                  cmd_stop,
    input  logic                  consumer_release,
    frame_capture_ctrl_if.slave   bus,
    output logic [31:0]           front_addr,
    output logic                  front_valid,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [15:0]           frames_captured,
    output logic [15:0]           frames_dropped,
    output logic                  swap_timeout,
    output logic                  busy
);

    localparam int TW = $clog2(SWAP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SWAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        DROP,
        SWAP
    } state_e;

    state_e        state_q, state_d;
    logic          single_q, single_d;
    logic          stop_q, stop_d;
    logic [31:0]   front_q, front_d;
    logic [31:0]   back_q, back_d;
    logic          fv_q, fv_d;
    logic          bf_q, bf_d;
    logic [15:0]   cap_q, cap_d;
    logic [15:0]   drop_q, drop_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          req_q, req_d;
    logic          tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;

    logic beat, sop_beat, eop_beat;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The SOP beat that opens a frame is forwarded from ARM already,
    // so the buffer receives the whole frame.
    always_comb begin
        bus.stream_ready_out = 1'b1;
        bus.out_valid        = 1'b0;
        unique case (state_q)
            ARM: begin
                if (bus.stream_sop && bf_q) begin
                    bus.stream_ready_out = bus.stream_ready_in;
                    bus.out_valid        = bus.stream_valid;
                end
            end
            CAPTURE: begin
                bus.stream_ready_out = bus.stream_ready_in;
                bus.out_valid        = bus.stream_valid;
            end
            SWAP:    bus.stream_ready_out = 1'b0;
            default: ;
        endcase
    end

    assign beat     = bus.stream_valid && bus.stream_ready_out;
    assign sop_beat = beat && bus.stream_sop;
    assign eop_beat = beat && bus.stream_eop;

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        stop_d   = stop_q;
        front_d  = front_q;
        back_d   = back_q;
        fv_d     = fv_q;
        bf_d     = bf_q;
        cap_d    = cap_q;
        drop_d   = drop_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        tmo_d    = tmo_q;
        timer_d  = timer_q;

        if (consumer_release && fv_q) bf_d = 1'b1;
        if (cmd_start || cmd_single) tmo_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!cmd_stop && (cmd_start || cmd_single)) begin
                    state_d  = ARM;
                    single_d = cmd_single;
                end
            end
            ARM: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (sop_beat) begin
                    if (!bf_q) begin
                        if (eop_beat) drop_d = sat_inc(drop_q);
                        else          state_d = DROP;
                    end else begin
                        state_d = eop_beat ? SWAP : CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (cmd_stop) stop_d = 1'b1;
                if (sop_beat) begin
                    abort_d = 1'b1;
                    drop_d  = sat_inc(drop_q);
                end
                if (eop_beat) state_d = SWAP;
            end
            DROP: begin
                if (eop_beat) drop_d = sat_inc(drop_q);
                if (cmd_stop)      state_d = IDLE;
                else if (eop_beat) state_d = ARM;
            end
            SWAP: begin
                if (cmd_stop) stop_d = 1'b1;
                if (bus.dma_swap_ack) begin
                    front_d = back_q;
                    back_d  = front_q;
                    fv_d    = 1'b1;
                    // A coincident release frees the old front, now the back.
                    bf_d    = consumer_release && fv_q;
                    done_d  = 1'b1;
                    cap_d   = sat_inc(cap_q);
                    state_d = (single_q || stop_q || cmd_stop) ? IDLE : ARM;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == SWAP && state_q != SWAP) timer_d = '0;
        if (state_d == IDLE) stop_d = 1'b0;
        req_d  = (state_d == SWAP);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            stop_q   <= 1'b0;
            front_q  <= BUF1_ADDR;
            back_q   <= BUF0_ADDR;
            fv_q     <= 1'b0;
            bf_q     <= 1'b1;
            cap_q    <= '0;
            drop_q   <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            req_q    <= 1'b0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            stop_q   <= stop_d;
            front_q  <= front_d;
            back_q   <= back_d;
            fv_q     <= fv_d;
            bf_q     <= bf_d;
            cap_q    <= cap_d;
            drop_q   <= drop_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            req_q    <= req_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.dma_write_addr = back_q;
    assign bus.dma_swap_req   = req_q;
    assign front_addr         = front_q;
    assign front_valid        = fv_q;
    assign frame_done         = done_q;
    assign frame_abort        = abort_q;
    assign frames_captured    = cap_q;
    assign frames_dropped     = drop_q;
    assign swap_timeout       = tmo_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: forwarded beats and
// done/abort pulses are checked against a queue of expected events.
module tb_frame_capture_ctrl;

    localparam logic [31:0] B0  = 32'h0800_0000;
    localparam logic [31:0] B1  = 32'h0804_0000;
    localparam int          TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_single = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        consumer_release = 1'b0;
    logic [31:0] front_addr;
    logic        front_valid;
    logic        frame_done;
    logic        frame_abort;
    logic [15:0] frames_captured;
    logic [15:0] frames_dropped;
    logic        swap_timeout;
    logic        busy;

    frame_capture_ctrl_if bus ();

    frame_capture_ctrl #(
        .BUF0_ADDR   (B0),
        .BUF1_ADDR   (B1),
        .SWAP_TIMEOUT(TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_start       (cmd_start),
        .cmd_single      (cmd_single),
        .cmd_stop        (cmd_stop),
        .consumer_release(consumer_release),
        .bus             (bus),
        .front_addr      (front_addr),
        .front_valid     (front_valid),
        .frame_done      (frame_done),
        .frame_abort     (frame_abort),
        .frames_captured (frames_captured),
        .frames_dropped  (frames_dropped),
        .swap_timeout    (swap_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef enum {EV_BEAT, EV_DONE, EV_ABORT} ev_k;
    typedef struct {
        ev_k         k;
        logic [31:0] a;
        logic [15:0] n;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic sb(ev_k k, logic [31:0] a, logic [15:0] n);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL sb_%s unexpected got a=%h n=%0d required none",
                     k.name(), a, n);
            return;
        end
        e = expq.pop_front();
        if (e.k != k || e.a !== a || e.n !== n) begin
            errors++;
            $display("FAIL sb_%s got a=%h n=%0d required %s a=%h n=%0d",
                     k.name(), a, n, e.k.name(), e.a, e.n);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (frame_done)  sb(EV_DONE, front_addr, frames_captured);
                if (frame_abort) sb(EV_ABORT, 32'd0, frames_dropped);
                if (bus.out_valid && bus.stream_ready_in)
                    sb(EV_BEAT, {30'd0, bus.stream_sop, bus.stream_eop}, 16'd0);
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(logic st, logic sg, logic sp);
        cmd_start  = st;
        cmd_single = sg;
        cmd_stop   = sp;
        tick();
        cmd_start  = 1'b0;
        cmd_single = 1'b0;
        cmd_stop   = 1'b0;
    endtask

    task automatic release_front();
        consumer_release = 1'b1;
        tick();
        consumer_release = 1'b0;
    endtask

    task automatic beat(logic sop, logic eop, logic fwd, output int waits);
        int n = 0;
        if (fwd) expq.push_back('{EV_BEAT, {30'd0, sop, eop}, 16'd0});
        bus.stream_valid = 1'b1;
        bus.stream_sop   = sop;
        bus.stream_eop   = eop;
        #1;
        while (!bus.stream_ready_out && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL beat_stall got stalled required ready");
        end
        tick();
        bus.stream_valid = 1'b0;
        bus.stream_sop   = 1'b0;
        bus.stream_eop   = 1'b0;
        waits = n;
    endtask

    task automatic frame(int len, logic fwd);
        int w;
        for (int i = 0; i < len; i++)
            beat(i == 0, i == len - 1, fwd, w);
    endtask

    task automatic do_swap(int dly, logic [31:0] fa, logic [15:0] cap, logic rel);
        int n = 0;
        while (!bus.dma_swap_req && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL swap_req got 0 required 1");
        end
        tick(dly);
        expq.push_back('{EV_DONE, fa, cap});
        bus.dma_swap_ack = 1'b1;
        consumer_release = rel;
        tick();
        bus.dma_swap_ack = 1'b0;
        consumer_release = 1'b0;
        tick();
    endtask

    initial begin
        int w;
        int n;
        bus.stream_valid    = 1'b0;
        bus.stream_sop      = 1'b0;
        bus.stream_eop      = 1'b0;
        bus.stream_ready_in = 1'b1;
        bus.dma_swap_ack    = 1'b0;
        #12;
        chk("rst_rdy", {31'd0, bus.stream_ready_out}, 32'd1);
        chk("rst_front", front_addr, B1);
        chk("rst_back", bus.dma_write_addr, B0);
        chk("rst_fv", {31'd0, front_valid}, 32'd0);
        chk("rst_cnt", {frames_captured, frames_dropped}, 32'd0);
        chk("rst_misc", {28'd0, busy, swap_timeout, bus.dma_swap_req, frame_done}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Continuous capture, one 4-beat frame, with a backpressure stall.
        cmd(1, 0, 0);
        chk("arm_busy", {31'd0, busy}, 32'd1);
        beat(1, 0, 1, w);
        bus.stream_ready_in = 1'b0;
        bus.stream_valid    = 1'b1;
        #1;
        chk("bp_rdy", {31'd0, bus.stream_ready_out}, 32'd0);
        tick(2);
        bus.stream_ready_in = 1'b1;
        beat(0, 0, 1, w);
        beat(0, 0, 1, w);
        beat(0, 1, 1, w);
        do_swap(3, B0, 16'd1, 1'b0);
        chk("t1_cap", {16'd0, frames_captured}, 32'd1);
        chk("t1_front", front_addr, B0);
        chk("t1_back", bus.dma_write_addr, B1);
        chk("t1_fv_busy", {30'd0, front_valid, busy}, 32'd3);

        // No release: the next frame is dropped.
        frame(3, 0);
        chk("t2_drop", {16'd0, frames_dropped}, 32'd1);
        chk("t2_cap", {16'd0, frames_captured}, 32'd1);

        // Release coincident with ack keeps the new back buffer free.
        release_front();
        frame(2, 1);
        do_swap(3, B1, 16'd2, 1'b1);
        chk("t3_front", front_addr, B1);
        chk("t3_back", bus.dma_write_addr, B0);

        // Stop mid-capture finishes the frame, then idles.
        beat(1, 0, 1, w);
        cmd(0, 0, 1);
        beat(0, 0, 1, w);
        beat(0, 1, 1, w);
        do_swap(2, B0, 16'd3, 1'b0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_cnt", {frames_captured, frames_dropped}, {16'd3, 16'd1});

        // Second SOP inside a frame aborts and restarts.
        release_front();
        cmd(1, 0, 0);
        beat(1, 0, 1, w);
        beat(0, 0, 1, w);
        beat(1, 0, 1, w);
        expq.push_back('{EV_ABORT, 32'd0, 16'd2});
        beat(0, 0, 1, w);
        beat(0, 1, 1, w);
        do_swap(3, B1, 16'd4, 1'b0);
        chk("t5_cnt", {frames_captured, frames_dropped}, {16'd4, 16'd2});
        cmd(0, 0, 1);
        chk("t5_stop_arm", {31'd0, busy}, 32'd0);

        // Start and single together: single wins.
        release_front();
        cmd(1, 1, 0);
        frame(2, 1);
        do_swap(3, B0, 16'd5, 1'b0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                beat(i == 0, i == 2, 0, w);
                chk("t6_flush", w, 32'd0);
            end
        end
        chk("t6_cap", {16'd0, frames_captured}, 32'd5);
        cmd(1, 0, 1);
        chk("t6_startstop", {31'd0, busy}, 32'd0);

        // Swap ack never comes.
        release_front();
        cmd(1, 0, 0);
        frame(2, 1);
        n = 0;
        while (bus.dma_swap_req && n < 50) begin
            tick();
            n++;
        end
        chk("t7_req_len", n, TMO);
        chk("t7_tmo_busy", {30'd0, swap_timeout, busy}, 32'd2);
        chk("t7_front", front_addr, B0);
        chk("t7_back", bus.dma_write_addr, B1);
        chk("t7_cap", {16'd0, frames_captured}, 32'd5);
        cmd(1, 0, 0);
        chk("t7_clr", {30'd0, swap_timeout, busy}, 32'd1);

        // Reset mid-frame.
        beat(1, 0, 1, w);
        beat(0, 0, 1, w);
        reset_n = 1'b0;
        #1;
        chk("t8_rdy", {31'd0, bus.stream_ready_out}, 32'd1);
        chk("t8_cnt", {frames_captured, frames_dropped}, 32'd0);
        chk("t8_addr", front_addr ^ bus.dma_write_addr, B0 ^ B1);
        chk("t8_front", front_addr, B1);
        chk("t8_busy", {30'd0, busy, bus.dma_swap_req}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        chk("sb_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

endmodule
